// File: rtl/fifo_sync_multi_pkg.sv
// -----------------------------------------------------------------------------
// fifo_sync_multi_pkg
// Shared definitions for the multi-channel gray pointer synchroniser.
//   STAGES_MIN/STAGES_MAX : legal synchroniser depth range
//   N_CH_MIN/N_CH_MAX     : legal channel count range
//   GRAY_W_MAX            : widest pointer gray2bin can convert
//   gray2bin()            : gray-to-binary conversion (MSB copied, then
//                           each lower bit XORed with the bit above)
// -----------------------------------------------------------------------------
package fifo_sync_multi_pkg;

    localparam int STAGES_MIN = 2;
    localparam int STAGES_MAX = 4;
    localparam int N_CH_MIN   = 1;
    localparam int N_CH_MAX   = 8;
    localparam int GRAY_W_MAX = 32;

    // Works on a zero-extended pointer: leading zero gray bits give leading
    // zero binary bits, so callers can truncate the result to their width.
    function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] g);
        logic [GRAY_W_MAX-1:0] b;
        b[GRAY_W_MAX-1] = g[GRAY_W_MAX-1];
        for (int i = GRAY_W_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_sync_multi_chan.sv
// -----------------------------------------------------------------------------
// fifo_sync_chan
// One channel of the gray pointer synchroniser: an STAGES-deep flop chain,
// a history register of the last synchronised sample, a registered binary
// conversion, a change pulse and a sticky multi-bit-change error flag.
// Ports:
//   wclk         : clock
//   wrst         : synchronous active-high reset
//   i_ptr_gray   : gray pointer from the foreign domain
//   i_err_clr    : clears o_gray_err (a new error at the same edge wins)
//   i_sync_valid : shared flush-complete flag; gates o_ptr_chg / error set
//   o_sync_gray  : last chain stage
//   o_sync_bin   : binary of o_sync_gray, one edge later
//   o_ptr_chg    : one-cycle pulse aligned with the new o_sync_bin
//   o_gray_err   : sticky flag, >1 bit changed between consecutive samples
// -----------------------------------------------------------------------------
module fifo_sync_chan
    import fifo_sync_multi_pkg::*;
#(
    parameter int PW     = 5,
    parameter int STAGES = 2
) (
    input  logic          wclk,
    input  logic          wrst,
    input  logic [PW-1:0] i_ptr_gray,
    input  logic          i_err_clr,
    input  logic          i_sync_valid,
    output logic [PW-1:0] o_sync_gray,
    output logic [PW-1:0] o_sync_bin,
    output logic          o_ptr_chg,
    output logic          o_gray_err
);

    logic [PW-1:0] r_stage [STAGES];
    logic [PW-1:0] r_hist;
    logic [PW-1:0] r_bin;
    logic          r_chg;
    logic          r_err;

    logic [PW-1:0] w_last;
    logic [PW-1:0] w_diff;
    logic          w_multi;

    assign w_last  = r_stage[STAGES-1];
    assign w_diff  = w_last ^ r_hist;
    // A legal gray step (including the wrap back to zero) flips exactly one bit.
    assign w_multi = ($countones(w_diff) > 1);

    always_ff @(posedge wclk) begin
        if (wrst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_stage[k] <= '0;
            end
            r_hist <= '0;
            r_bin  <= '0;
            r_chg  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_stage[0] <= i_ptr_gray;
            for (int k = 1; k < STAGES; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
            r_hist <= w_last;
            r_bin  <= PW'(gray2bin(GRAY_W_MAX'(w_last)));
            // Compared against the history so the pulse lands with r_bin.
            r_chg  <= i_sync_valid & (w_last != r_hist);
            // Set dominates clear.
            r_err  <= (i_sync_valid & w_multi) | (r_err & ~i_err_clr);
        end
    end

    assign o_sync_gray = w_last;
    assign o_sync_bin  = r_bin;
    assign o_ptr_chg   = r_chg;
    assign o_gray_err  = r_err;

endmodule

// File: rtl/fifo_sync_multi.sv
// -----------------------------------------------------------------------------
// fifo_sync_multi
// N_CH independent gray pointer synchronisers sharing one flush counter.
// Ports:
//   wclk       : clock for all state
//   wrst       : synchronous active-high reset
//   ptr_gray   : packed gray pointers, channel c at [c*(ASIZE+1) +: ASIZE+1]
//   err_clr    : per-channel clear of gray_err
//   sync_gray  : synchronised gray pointers (STAGES edges latency)
//   sync_bin   : binary of sync_gray (STAGES+1 edges latency)
//   ptr_chg    : per-channel one-cycle change pulse
//   gray_err   : per-channel sticky multi-bit-change flag
//   sync_valid : chain flushed since reset
// -----------------------------------------------------------------------------
module fifo_sync_multi
    import fifo_sync_multi_pkg::*;
#(
    parameter int N_CH   = 2,
    parameter int ASIZE  = 4,
    parameter int STAGES = 2
) (
    input  logic                      wclk,
    input  logic                      wrst,
    input  logic [N_CH*(ASIZE+1)-1:0] ptr_gray,
    input  logic [N_CH-1:0]           err_clr,
    output logic [N_CH*(ASIZE+1)-1:0] sync_gray,
    output logic [N_CH*(ASIZE+1)-1:0] sync_bin,
    output logic [N_CH-1:0]           ptr_chg,
    output logic [N_CH-1:0]           gray_err,
    output logic                      sync_valid
);

    localparam int PW = ASIZE + 1;
    localparam int CW = $clog2(STAGES + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(STAGES + 1);

    generate
        if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
            $error("fifo_sync_multi: STAGES out of range");
        end
        if (N_CH < N_CH_MIN || N_CH > N_CH_MAX) begin : g_bad_nch
            $error("fifo_sync_multi: N_CH out of range");
        end
        if (PW > GRAY_W_MAX) begin : g_bad_asize
            $error("fifo_sync_multi: ASIZE too large");
        end
    endgenerate

    // Flush counter: sync_valid rises once every stage, the history register
    // and the binary register all hold post-reset samples.
    logic [CW-1:0] r_cnt;
    logic          w_sync_valid;

    assign w_sync_valid = (r_cnt == CNT_FULL);

    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_cnt <= '0;
        end else if (!w_sync_valid) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign sync_valid = w_sync_valid;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_chan
            fifo_sync_chan #(
                .PW     (PW),
                .STAGES (STAGES)
            ) u_chan (
                .wclk         (wclk),
                .wrst         (wrst),
                .i_ptr_gray   (ptr_gray[gi*PW +: PW]),
                .i_err_clr    (err_clr[gi]),
                .i_sync_valid (w_sync_valid),
                .o_sync_gray  (sync_gray[gi*PW +: PW]),
                .o_sync_bin   (sync_bin[gi*PW +: PW]),
                .o_ptr_chg    (ptr_chg[gi]),
                .o_gray_err   (gray_err[gi])
            );
        end
    endgenerate

endmodule

// File: doc/fifo_sync_multi.md
FIFO_SYNC_MULTI -- requirements
Module: fifo_sync_multi

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of independent pointer channels, range 1..8.
REQ-002 SHALL have parameter ASIZE, default 4: FIFO address width; each pointer is ASIZE+1 bits.
REQ-003 SHALL have parameter STAGES, default 2: synchroniser depth, range 2..4.
REQ-004 SHALL have port wclk, input, 1: single clock for all state.
REQ-005 SHALL have port wrst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port ptr_gray, input, N_CH*(ASIZE+1): gray-coded pointers from the foreign domain; channel c occupies bits [c*(ASIZE+1) +: ASIZE+1].
REQ-007 SHALL have port err_clr, input, N_CH: per-channel clear for gray_err.
REQ-008 SHALL have port sync_gray, output, N_CH*(ASIZE+1): synchronised gray pointers.
REQ-009 SHALL have port sync_bin, output, N_CH*(ASIZE+1): registered binary equivalent of sync_gray.
REQ-010 SHALL have port ptr_chg, output, N_CH: one-cycle pulse when a channel's synchronised pointer changed.
REQ-011 SHALL have port gray_err, output, N_CH: sticky flag, more than one bit changed between consecutive synchronised samples.
REQ-012 SHALL have port sync_valid, output, 1: synchroniser pipeline flushed since reset.

Function
REQ-013 SHALL implement, per channel, a chain s1..sSTAGES: s1 <= ptr_gray, sk <= s(k-1) each wclk edge; sync_gray = sSTAGES.
REQ-014 SHALL give sync_gray a latency of exactly STAGES edges from ptr_gray.
REQ-015 SHALL hold, per channel, a history register h <= sSTAGES each edge.
REQ-016 SHALL register sync_bin <= gray2bin(sSTAGES) each edge (latency STAGES+1); gray2bin: b[MSB]=g[MSB], b[i]=b[i+1]^g[i].
REQ-017 SHALL register ptr_chg[c] <= sync_valid & (sSTAGES != h), so that it is cycle-aligned with the new sync_bin.
REQ-018 SHALL set gray_err[c] at an edge where sync_valid=1 and popcount(sSTAGES ^ h) > 1.
REQ-019 SHALL keep gray_err[c] at 1 until an edge with err_clr[c]=1; set SHALL win over clear at the same edge.
REQ-020 SHALL use a saturating counter cnt, cleared by reset, incrementing each edge up to STAGES+1; sync_valid = (cnt == STAGES+1).
REQ-021 SHALL suppress ptr_chg and gray_err setting while sync_valid=0.
REQ-022 SHALL treat wrap-around (e.g. gray 10000 -> 00000 for ASIZE=4) as a legal single-bit change, with no error.
REQ-023 SHALL keep channels fully independent; activity or err_clr on one channel SHALL NOT affect another.

Reset
REQ-024 SHALL clear, at an edge with wrst=1, all chain stages, h, sync_bin, ptr_chg, gray_err and cnt to 0; sync_gray and sync_valid therefore read 0.
REQ-025 SHALL have a reset asserted mid-operation override all other updates at that edge and restart the sync_valid flush count.

Structure
REQ-026 SHALL place the STAGES range limits and a gray2bin function in the shared fifo package.
REQ-027 SHALL contain one sub-module, fifo_sync_chan, instantiated N_CH times by generate; cnt and sync_valid SHALL be shared at top level.

Verification
REQ-028 Reset-flush scenario: release wrst with STAGES=2 -> sync_valid rises at the 3rd edge after release; ptr_chg=0 and gray_err=0 throughout.
REQ-029 Step scenario: ch0 ptr_gray 00000 -> 00001 at edge t -> sync_gray=00001 after edge t+2, sync_bin=00001 and ptr_chg[0]=1 for exactly one cycle after edge t+3.
REQ-030 Wrap scenario: increment ch1 through the full gray sequence, 32 values for ASIZE=4 -> sync_bin counts 0..31..0 and gray_err[1] stays 0.
REQ-031 Error scenario: ch0 jumps 00000 -> 00011 -> gray_err[0]=1 at edge t+3 and holds; err_clr[0] pulse -> 0; simultaneous new violation and clear -> stays 1.
REQ-032 Independence and reset scenario: N_CH=4, STAGES=4; toggle ch2 only -> only ptr_chg[2] pulses; assert wrst mid-stream -> all outputs 0 next edge and sync_valid returns after 5 edges.
